// File: rtl/steer_pwm_driver.sv
// Turns the PID steering command into slew-limited left/right wheel duties and two glitch-free PWM outputs.
// Duty changes land only on the period wrap; a command watchdog ramps both wheels to stop when commands stop.
module steer_pwm_driver #(
    parameter int PWM_PERIOD     = 1000,
    parameter int BASE_DUTY      = 600,
    parameter int STEER_GAIN     = 60,
    parameter int CMD_LIMIT      = 5,
    parameter int SLEW_STEP      = 10,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    input  logic        enable,
    output logic        pwm_left,
    output logic        pwm_right,
    output logic [15:0] duty_left,
    output logic [15:0] duty_right,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(PWM_PERIOD - 1);
    localparam logic [31:0] WD_MAX   = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [31:0]        wd_cnt;
    logic [15:0]        pwm_cnt;
    logic signed [31:0] cmd_lat;
    logic signed [31:0] cmd_clamped;
    logic signed [31:0] raw_left;
    logic signed [31:0] raw_right;
    logic [15:0]        tgt_left;
    logic [15:0]        tgt_right;
    logic               wrap;
    logic               expire;

    function automatic logic [15:0] sat_duty(input logic signed [31:0] v);
        if (v < 0)
            return 16'd0;
        else if (v > PWM_PERIOD)
            return 16'(PWM_PERIOD);
        else
            return v[15:0];
    endfunction

    // Step at most SLEW_STEP toward the target, landing exactly on it when close.
    function automatic logic [15:0] slew(input logic [15:0] duty, input logic [15:0] tgt);
        logic signed [31:0] diff;
        diff = signed'({16'd0, tgt}) - signed'({16'd0, duty});
        if (diff > SLEW_STEP)
            return duty + 16'(SLEW_STEP);
        else if (diff < -SLEW_STEP)
            return duty - 16'(SLEW_STEP);
        else
            return tgt;
    endfunction

    always_comb begin
        cmd_clamped = signed'(cmd);
        if (signed'(cmd) > CMD_LIMIT)
            cmd_clamped = CMD_LIMIT;
        else if (signed'(cmd) < -CMD_LIMIT)
            cmd_clamped = -CMD_LIMIT;
    end

    assign raw_left  = BASE_DUTY + STEER_GAIN * cmd_lat;
    assign raw_right = BASE_DUTY - STEER_GAIN * cmd_lat;
    assign tgt_left  = (state == ST_RUN) ? sat_duty(raw_left)  : 16'd0;
    assign tgt_right = (state == ST_RUN) ? sat_duty(raw_right) : 16'd0;
    assign wrap      = (pwm_cnt == CNT_LAST);
    // A command on the expiry edge keeps the watchdog from tripping.
    assign expire    = !cmd_valid && (wd_cnt >= WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            timeout <= 1'b0;
            wd_cnt  <= 32'd0;
        end else begin
            if (state == ST_IDLE || !enable || cmd_valid)
                wd_cnt <= 32'd0;
            else if (wd_cnt < WD_MAX)
                wd_cnt <= wd_cnt + 32'd1;

            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (enable)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b0;
                    end else if (expire) begin
                        state   <= ST_STALE;
                        timeout <= 1'b1;
                    end
                end
                ST_STALE: begin
                    if (!enable) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b0;
                    end else if (cmd_valid) begin
                        state   <= ST_RUN;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_lat    <= 32'sd0;
            pwm_cnt    <= 16'd0;
            duty_left  <= 16'd0;
            duty_right <= 16'd0;
            pwm_left   <= 1'b0;
            pwm_right  <= 1'b0;
        end else begin
            if (cmd_valid)
                cmd_lat <= cmd_clamped;

            pwm_cnt <= wrap ? 16'd0 : pwm_cnt + 16'd1;

            // Dropping enable zeroes the duties immediately rather than ramping.
            if (!enable || state == ST_IDLE) begin
                duty_left  <= 16'd0;
                duty_right <= 16'd0;
            end else if (wrap) begin
                duty_left  <= slew(duty_left, tgt_left);
                duty_right <= slew(duty_right, tgt_right);
            end

            pwm_left  <= (pwm_cnt < duty_left);
            pwm_right <= (pwm_cnt < duty_right);
        end
    end

endmodule

// File: tb/tb_steer_pwm_driver.sv
// Directed bench for steer_pwm_driver: soft start, steering, clamping, watchdog, enable drop, async reset, saturation.
module tb_steer_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        enable;
    logic        pwm_left, pwm_right, timeout;
    logic [15:0] duty_left, duty_right;
    logic        pwm_left2, pwm_right2, timeout2;
    logic [15:0] duty_left2, duty_right2;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    steer_pwm_driver #(
        .PWM_PERIOD(100), .BASE_DUTY(60), .STEER_GAIN(6), .CMD_LIMIT(5),
        .SLEW_STEP(5), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .enable(enable),
        .pwm_left(pwm_left), .pwm_right(pwm_right), .duty_left(duty_left),
        .duty_right(duty_right), .timeout(timeout)
    );

    steer_pwm_driver #(
        .PWM_PERIOD(100), .BASE_DUTY(60), .STEER_GAIN(20), .CMD_LIMIT(5),
        .SLEW_STEP(5), .TIMEOUT_CYCLES(1000)
    ) dut_sat (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .enable(enable),
        .pwm_left(pwm_left2), .pwm_right(pwm_right2), .duty_left(duty_left2),
        .duty_right(duty_right2), .timeout(timeout2)
    );

    always #5 clk = ~clk;

    // Reference cycle count since reset release; cyc % 100 tracks the PWM phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_duty(input string tag, input int l, input int r);
        chk({tag, "_l"}, 32'(duty_left), 32'(l));
        chk({tag, "_r"}, 32'(duty_right), 32'(r));
    endtask

    task automatic count_high(output int nl, output int nr, output int nl2, output int nr2);
        nl = 0; nr = 0; nl2 = 0; nr2 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            nl  += int'(pwm_left);
            nr  += int'(pwm_right);
            nl2 += int'(pwm_left2);
            nr2 += int'(pwm_right2);
        end
    endtask

    initial begin
        int nl, nr, nl2, nr2;
        rst = 1'b1; enable = 1'b0; cmd = 32'd0; cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty_l", 32'(duty_left), 32'd0);
        chk("rst_duty_r", 32'(duty_right), 32'd0);
        chk("rst_pwm_l", 32'(pwm_left), 32'd0);
        chk("rst_pwm_r", 32'(pwm_right), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // Soft start: 5 counts per period up to 60.
        rst = 1'b0; enable = 1'b1; cmd = 32'd0; cmd_valid = 1'b1;
        wait_cyc(50);
        chk_duty("start_mid0", 0, 0);
        for (int w = 1; w <= 12; w++) begin
            wait_cyc(100 * w);
            chk_duty("start", 5 * w, 5 * w);
        end
        wait_cyc(1300);
        count_high(nl, nr, nl2, nr2);
        chk("start_pwm_l_high", 32'(nl), 32'd60);
        chk("start_pwm_r_high", 32'(nr), 32'd60);

        // Steer +3: targets 78/42.
        cmd = 32'd3;
        wait_cyc(1550);
        chk_duty("steer_mid", 65, 55);
        wait_cyc(1799);
        chk_duty("steer_prewrap", 75, 45);
        wait_cyc(1800);
        chk_duty("steer_done", 78, 42);

        // Clamp: +40 -> +5, 0x80000000 -> -5.
        cmd = 32'd40;
        wait_cyc(2100);
        chk_duty("clamp_pos", 90, 30);
        cmd = 32'h8000_0000;
        wait_cyc(2200);
        chk_duty("clamp_neg_step", 85, 35);
        wait_cyc(3300);
        chk_duty("clamp_neg", 30, 90);

        // Watchdog: last command latched on the edge to cyc 3301.
        cmd = 32'd0;
        wait_cyc(3301);
        cmd_valid = 1'b0;
        wait_cyc(4300);
        chk("wd_pre_trip", 32'(timeout), 32'd0);
        chk_duty("wd_pre_trip", 60, 60);
        wait_cyc(4301);
        chk("wd_trip", 32'(timeout), 32'd1);
        wait_cyc(4400);
        chk_duty("wd_ramp_down", 55, 55);
        wait_cyc(5500);
        chk_duty("wd_stopped", 0, 0);
        wait_cyc(5510);
        chk("wd_stopped_pwm_l", 32'(pwm_left), 32'd0);
        wait_cyc(5550);
        chk("wd_still_tripped", 32'(timeout), 32'd1);
        cmd_valid = 1'b1;
        wait_cyc(5551);
        cmd_valid = 1'b0;
        chk("wd_recover", 32'(timeout), 32'd0);
        wait_cyc(6500);
        chk_duty("wd_ramp_up", 50, 50);
        wait_cyc(6550);
        chk("wd_before_expiry", 32'(timeout), 32'd0);
        cmd_valid = 1'b1;
        wait_cyc(6551);
        cmd_valid = 1'b0;
        chk("wd_valid_on_expiry", 32'(timeout), 32'd0);
        wait_cyc(6552);
        chk("wd_valid_on_expiry_next", 32'(timeout), 32'd0);
        wait_cyc(6700);
        chk_duty("wd_back", 60, 60);
        wait_cyc(7550);
        chk("wd_second_pre", 32'(timeout), 32'd0);
        wait_cyc(7551);
        chk("wd_second_trip", 32'(timeout), 32'd1);
        cmd_valid = 1'b1;
        wait_cyc(7552);
        chk("wd_second_recover", 32'(timeout), 32'd0);
        chk_duty("wd_second_hold", 60, 60);

        // Enable drop mid-period.
        wait_cyc(7650);
        chk("en_pwm_l_before", 32'(pwm_left), 32'd1);
        enable = 1'b0;
        wait_cyc(7651);
        chk_duty("en_drop", 0, 0);
        chk("en_pwm_l_lag", 32'(pwm_left), 32'd1);
        wait_cyc(7652);
        chk("en_pwm_l_low", 32'(pwm_left), 32'd0);
        chk("en_pwm_r_low", 32'(pwm_right), 32'd0);
        wait_cyc(7700);
        enable = 1'b1;
        wait_cyc(8000);
        chk_duty("en_reramp", 15, 15);

        // Asynchronous reset between clock edges.
        wait_cyc(8010);
        chk("arst_pwm_l_before", 32'(pwm_left), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_pwm_l", 32'(pwm_left), 32'd0);
        chk("arst_pwm_r", 32'(pwm_right), 32'd0);
        chk("arst_duty_l", 32'(duty_left), 32'd0);
        chk("arst_duty_r", 32'(duty_right), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);

        // Saturation on the high-gain instance: 60 +/- 100 -> 100 / 0.
        @(negedge clk);
        rst = 1'b0; cmd = 32'd5; cmd_valid = 1'b1;
        wait_cyc(1000);
        chk("sat_mid_l", 32'(duty_left2), 32'd50);
        chk("sat_mid_r", 32'(duty_right2), 32'd0);
        wait_cyc(2000);
        chk("sat_l", 32'(duty_left2), 32'd100);
        chk("sat_r", 32'(duty_right2), 32'd0);
        chk_duty("sat_ref", 90, 30);
        count_high(nl, nr, nl2, nr2);
        chk("sat_pwm_l_high", 32'(nl2), 32'd100);
        chk("sat_pwm_r_high", 32'(nr2), 32'd0);
        chk("ref_pwm_l_high", 32'(nl), 32'd90);
        chk("ref_pwm_r_high", 32'(nr), 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/steer_pwm_driver.md
Name: steer_pwm_driver

Overview:
Downstream stage of the steering PID controller. Takes the PID's signed steering command (nominal range -5..+5) and its cmd_valid strobe, and turns them into left/right wheel duty targets around a base speed. Duty changes are slew-rate limited. Two glitch-free PWM outputs drive the motor H-bridge. A command watchdog ramps both wheels to stop if the controller goes silent.

Parameters:
PWM_PERIOD, 1000, PWM period in clk cycles; range 2..65535
BASE_DUTY, 600, duty count for both wheels at cmd=0
STEER_GAIN, 60, duty counts added (left) / subtracted (right) per command unit
CMD_LIMIT, 5, command magnitude clamp
SLEW_STEP, 10, maximum duty change per wheel per PWM period
TIMEOUT_CYCLES, 5000000, clk cycles without cmd_valid before the watchdog trips

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cmd  input  32  signed steering command from the PID stage; positive = turn right (left wheel faster)
cmd_valid  input  1  cmd is sampled on any clk edge where this is high
enable  input  1  drive enable; low forces stop
pwm_left  output  1  left wheel PWM, registered
pwm_right  output  1  right wheel PWM, registered
duty_left  output  16  current applied left duty (0..PWM_PERIOD)
duty_right  output  16  current applied right duty (0..PWM_PERIOD)
timeout  output  1  high while the watchdog is tripped

Behaviour:
- Reset (async, rst high): all outputs 0; PWM counter 0; latched command 0; watchdog counter 0; state IDLE.
- Command latch: on cmd_valid, store clamp(cmd, -CMD_LIMIT, +CMD_LIMIT) as a signed 32-bit value.
- Targets, computed in signed 32-bit arithmetic:
  - tgt_l = BASE_DUTY + STEER_GAIN*c
  - tgt_r = BASE_DUTY - STEER_GAIN*c
  - each saturated to [0, PWM_PERIOD]
- States:
  - IDLE: targets forced to 0 and duties held at 0. Go to RUN when enable=1.
  - RUN: targets follow the latched command. Go to STALE when the watchdog reaches TIMEOUT_CYCLES. Go to IDLE when enable=0.
  - STALE: timeout=1 and targets forced to 0, so duties slew down to 0. Go to RUN on cmd_valid; timeout clears on the following cycle. Go to IDLE when enable=0.
- Watchdog:
  - Counts clk cycles in RUN and resets to 0 on every cmd_valid.
  - Saturates at TIMEOUT_CYCLES.
  - If cmd_valid and expiry occur on the same edge, cmd_valid wins and the state stays RUN.
  - Held at 0 in IDLE.
- PWM counter:
  - Free-runs 0..PWM_PERIOD-1, then wraps to 0.
  - Runs in all states except reset.
- Duty update (only on the edge where the counter wraps PWM_PERIOD-1 -> 0):
  - Each duty moves toward its target by min(|target-duty|, SLEW_STEP).
  - Duty never changes mid-period (glitch-free).
  - Exception: entering IDLE forces both duties to 0 on the same edge as the transition; no ramping.
- PWM output: pwm_x <= (counter < duty_x), registered, so one cycle of latency from the counter.
  - duty = 0 gives a constant low output; duty = PWM_PERIOD gives a constant high output.
- Leaving IDLE: duties ramp up from 0 at SLEW_STEP per period.
- A new cmd mid-period changes the target only; it is applied at the next wrap.

Test Plan:
Parameters for tests 1-5: PWM_PERIOD=100, BASE_DUTY=60, STEER_GAIN=6, SLEW_STEP=5, TIMEOUT_CYCLES=1000.
1. Soft start: reset, then enable=1 with cmd=0 valid -> duties step 5,10,...,60, one step per 100 cycles, reaching 60 after 12 wraps. Both PWM outputs are then high for 60 of every 100 cycles.
2. Steer: from steady state, pulse cmd=+3 -> targets 78/42. After 4 wraps duty_left=78 and duty_right=42. No duty change occurs mid-period.
3. Clamp: cmd=+40 -> 90/30. cmd=32'h80000000 -> clamped to -5, giving 30/90.
4. Watchdog: withhold cmd_valid for 1000 cycles -> timeout=1 and duties ramp to 0. Pulse cmd=0 -> timeout=0 on the next cycle and duties ramp back to 60. Also pulse cmd_valid exactly on the expiry edge -> timeout stays 0.
5. Enable drop and reset: enable=0 mid-period -> duties 0 on the next edge and PWM outputs low one cycle later. Assert rst asynchronously mid-period -> all outputs 0 immediately, without a clock edge.
6. Saturation: configure BASE_DUTY=60, STEER_GAIN=20 and apply cmd=+5 -> duty_left saturates to 100 (pwm_left constant high) and duty_right to 0 (pwm_right constant low).
